// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant across functional units into a
// single registered broadcast slot with consumer backpressure and flush.
module cdb_arbiter #(
    parameter int NUM_FU    = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_FU-1:0]           fu_valid_in,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data_in,
    input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_in,
    output logic [NUM_FU-1:0]           fu_read_out,
    input  logic                        cdb_ready_in,
    input  logic                        flush_in,
    output logic                        cdb_valid_out,
    output logic [DATA_W-1:0]           cdb_data_out,
    output logic [ROB_IDX_W-1:0]        cdb_rob_idx_out,
    output logic [2:0]                  cdb_src_out,
    output logic [15:0]                 grant_count_out
);

    localparam int SEL_W  = 3;
    localparam int CAND_W = SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST_FU = SEL_W'(NUM_FU - 1);

    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     grant_idx;
    logic [CAND_W-1:0]    cand;
    logic                 any_hit;
    logic                 slot_free;
    logic                 grant_en;
    logic [7:0]           valid_ext;
    logic [DATA_W-1:0]    data_arr [8];
    logic [ROB_IDX_W-1:0] tag_arr  [8];

    // Unpack into 8-entry arrays so a 3-bit select indexes every FU slot.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            data_arr[k] = '0;
            tag_arr[k]  = '0;
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            data_arr[k] = fu_data_in[k*DATA_W +: DATA_W];
            tag_arr[k]  = fu_rob_idx_in[k*ROB_IDX_W +: ROB_IDX_W];
        end
        valid_ext = 8'(fu_valid_in);
    end

    always_comb begin
        any_hit   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            cand = {1'b0, ptr} + CAND_W'(i);
            if (cand >= CAND_W'(NUM_FU))
                cand = cand - CAND_W'(NUM_FU);
            if (!any_hit && valid_ext[cand[SEL_W-1:0]]) begin
                any_hit   = 1'b1;
                grant_idx = cand[SEL_W-1:0];
            end
        end
    end

    // Reset is folded in so the grant drops asynchronously with rst_n_in.
    always_comb begin
        slot_free   = !cdb_valid_out || cdb_ready_in;
        grant_en    = any_hit && slot_free && !flush_in && rst_n_in;
        fu_read_out = '0;
        for (int unsigned k = 0; k < NUM_FU; k++)
            fu_read_out[k] = grant_en && (grant_idx == SEL_W'(k));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr             <= '0;
            cdb_valid_out   <= 1'b0;
            cdb_data_out    <= '0;
            cdb_rob_idx_out <= '0;
            cdb_src_out     <= '0;
            grant_count_out <= '0;
        end else if (grant_en) begin
            cdb_valid_out   <= 1'b1;
            cdb_data_out    <= data_arr[grant_idx];
            cdb_rob_idx_out <= tag_arr[grant_idx];
            cdb_src_out     <= grant_idx;
            ptr             <= (grant_idx == LAST_FU) ? '0 : grant_idx + 1'b1;
            grant_count_out <= grant_count_out + 16'd1;
        end else if (flush_in || cdb_ready_in) begin
            cdb_valid_out   <= 1'b0;
        end
    end

endmodule
